demo_cnt_bank: RTL
==================

DEMO_CNT_BANK -- requirements
Module: demo_cnt_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels, range 1..8.
REQ-002 Parameter CNT_BITS, default 32: counter width per channel, range 8..32.
REQ-003 Parameter DEB_BITS, default 16: debounce counter width; an input is stable after 2^DEB_BITS cycles.
REQ-004 clk_lb  input  1  single clock for all logic; one clock; reset is asynchronous and active-low.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 btn_clr  input  NUM_CH  raw per-channel clear buttons, asynchronous.
REQ-007 btn_pause  input  NUM_CH  raw per-channel pause buttons, asynchronous.
REQ-008 lb_cs  input  1  localbus chip select for this block.
REQ-009 lb_wr, lb_rd  input  1 each  localbus single-cycle write and read strobes.
REQ-010 lb_addr  input  4  word index into the register map.
REQ-011 lb_wr_d  input  32  write data; lb_rd_d  output  32  read data.
REQ-012 lb_rd_rdy  output  1  read-data-valid pulse.
REQ-013 led  output  8  top 8 bits of the counter of the channel selected by CTRL.sel.
REQ-014 sump_events  output  4*NUM_CH  per channel {tc, pause_db, state[1:0]}, channel 0 in the LSBs.

Function
REQ-015 Each button input passes a 2-flop synchronizer, then a debouncer; the debounced output changes only after the synchronized input has held a new value for 2^DEB_BITS consecutive cycles.
REQ-016 Register map: 0x0 CTRL (bit0 run, bits[10:8] sel, bits[23:16] stop_mode per channel); 0x1 CMD (write-only, bits[7:0] clear pulse per channel, reads 0); 0x2 STATUS (bits[15:0] state per channel, 2 bits each; bits[23:16] done flag per channel); 0x8+ch COUNT_ch (read value, write loads counter).
REQ-017 Each channel FSM has states RESET=0, PAUSE=1, COUNT=2, DONE=3.
REQ-018 Per-cycle priority: clear (btn or CMD) > load > pause > terminal > count.
REQ-019 Clear: counter <= 0, state <= RESET; the channel leaves RESET on the next cycle to COUNT if run=1, else to PAUSE.
REQ-020 Pause (debounced button high or run=0): counter holds, state <= PAUSE.
REQ-021 Count: counter increments by 1 per cycle, state = COUNT.
REQ-022 Terminal count is all-ones. With stop_mode=0 the counter wraps to 0 and tc pulses high for exactly the wrap cycle. With stop_mode=1 the counter holds all-ones, state <= DONE, and tc stays high; DONE exits only via clear or load.
REQ-023 Load: counter <= lb_wr_d[CNT_BITS-1:0] on the write cycle. Counting resumes on the following cycle. A load from DONE returns to COUNT or PAUSE per REQ-018.
REQ-024 Read: lb_cs&lb_rd in cycle N gives lb_rd_rdy=1 and valid lb_rd_d in cycle N+1 only. lb_rd_d=0 whenever lb_rd_rdy=0.
REQ-025 Addresses for channels >= NUM_CH and unmapped addresses read 0 and ignore writes. A sel value >= NUM_CH drives led=0.
REQ-026 led and sump_events are registered, one cycle behind counter/state.

Reset
REQ-027 On reset_n low, all flops clear asynchronously: counters 0, states RESET, debouncers 0, CTRL=0x00000001 (run=1, sel=0, stop_mode=0), led=0, lb_rd_d=0, lb_rd_rdy=0, sump_events=0.
REQ-028 Reset asserted mid-read suppresses lb_rd_rdy. After release, channels enter COUNT on the second clock edge.

Structure
REQ-029 Package demo_cnt_pkg holds the state encodings, register offsets and CTRL field positions.
REQ-030 Sub-module demo_debounce (synchronizer plus stability counter, DEB_BITS parameter) is instantiated 2*NUM_CH times.

Verification (NUM_CH=2, CNT_BITS=8, DEB_BITS=2)
REQ-031 Release reset, no stimulus -> ch0 counts 0,1,2,... from the second edge; after 255 it reads 0 and tc pulses one cycle.
REQ-032 Write CTRL=0x00010001, let ch0 reach 0xFF -> ch0 state DONE, STATUS bit16=1, count holds 0xFF; write CMD=0x1 -> count 0, state RESET, then COUNT.
REQ-033 Hold btn_pause[1] high for 3 cycles -> no effect; hold for 4 or more cycles -> ch1 enters PAUSE and holds its value; ch0 is unaffected.
REQ-034 Write COUNT_1=0x80 in the same cycle btn_clr[1] is debounced high -> ch1=0, state RESET (clear wins over load).
REQ-035 Read STATUS at cycle N -> lb_rd_rdy high only at N+1 with correct data; read address 0xA -> 0.
REQ-036 Assert reset_n low during a COUNT_0 read -> no lb_rd_rdy, all outputs 0 immediately.

Source files
------------

// File: rtl/demo_cnt_pkg.sv
// Shared definitions for the demo counter bank: channel state encodings,
// localbus register offsets and CTRL/STATUS field positions.
package demo_cnt_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_PAUSE = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } ch_state_e;

  localparam logic [3:0] ADDR_CTRL       = 4'h0;
  localparam logic [3:0] ADDR_CMD        = 4'h1;
  localparam logic [3:0] ADDR_STATUS     = 4'h2;
  localparam logic [3:0] ADDR_COUNT_BASE = 4'h8;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_SEL_LSB    = 8;
  localparam int CTRL_SEL_BITS   = 3;
  localparam int CTRL_STOP_LSB   = 16;
  localparam int STATUS_DONE_LSB = 16;
  localparam int MAX_CH          = 8;

  // Word address of the COUNT register belonging to channel ch.
  function automatic logic [3:0] count_addr(input int ch);
    return ADDR_COUNT_BASE + 4'(ch);
  endfunction

endpackage

// File: rtl/demo_debounce.sv
// Two-flop synchronizer followed by a stability counter: the output only
// follows the synchronized input after it has differed for 2^DEB_BITS cycles.
module demo_debounce #(
  parameter int DEB_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                db_q, db_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Any cycle where the input agrees with the output restarts the count.
    if (sync2_q != db_q) begin
      if (&cnt_q) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DEB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/demo_cnt_bank.sv
// Bank of NUM_CH independent up-counters with debounced clear/pause buttons,
// a localbus register interface, an LED view of one channel and debug events.
module demo_cnt_bank
  import demo_cnt_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_BITS = 32,
  parameter int DEB_BITS = 16
) (
  input  logic                  clk_lb,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     btn_clr,
  input  logic [NUM_CH-1:0]     btn_pause,
  input  logic                  lb_cs,
  input  logic                  lb_wr,
  input  logic                  lb_rd,
  input  logic [3:0]            lb_addr,
  input  logic [31:0]           lb_wr_d,
  output logic [31:0]           lb_rd_d,
  output logic                  lb_rd_rdy,
  output logic [7:0]            led,
  output logic [4*NUM_CH-1:0]   sump_events
);

  // ---------------------------------------------------------------- buttons
  logic [NUM_CH-1:0] clr_db;
  logic [NUM_CH-1:0] pause_db;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_deb
    demo_debounce #(.DEB_BITS(DEB_BITS)) u_clr_deb (
      .clk   (clk_lb),
      .rst_n (reset_n),
      .din   (btn_clr[gi]),
      .dout  (clr_db[gi])
    );
    demo_debounce #(.DEB_BITS(DEB_BITS)) u_pause_deb (
      .clk   (clk_lb),
      .rst_n (reset_n),
      .din   (btn_pause[gi]),
      .dout  (pause_db[gi])
    );
  end

  // ---------------------------------------------------------------- bus decode
  logic              wr_en;
  logic              rd_en;
  logic              ctrl_wr;
  logic [NUM_CH-1:0] load_en;
  logic [NUM_CH-1:0] cmd_clr;

  assign wr_en   = lb_cs & lb_wr;
  assign rd_en   = lb_cs & lb_rd;
  assign ctrl_wr = wr_en && (lb_addr == ADDR_CTRL);

  always_comb begin
    load_en = '0;
    cmd_clr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load_en[i] = wr_en && (lb_addr == count_addr(i));
      cmd_clr[i] = wr_en && (lb_addr == ADDR_CMD) && lb_wr_d[i];
    end
  end

  // ---------------------------------------------------------------- CTRL
  logic                     run_q, run_d;
  logic [CTRL_SEL_BITS-1:0] sel_q, sel_d;
  logic [MAX_CH-1:0]        stop_q, stop_d;

  always_comb begin
    run_d  = run_q;
    sel_d  = sel_q;
    stop_d = stop_q;
    if (ctrl_wr) begin
      run_d  = lb_wr_d[CTRL_RUN_BIT];
      sel_d  = lb_wr_d[CTRL_SEL_LSB +: CTRL_SEL_BITS];
      stop_d = lb_wr_d[CTRL_STOP_LSB +: MAX_CH];
    end
  end

  // ---------------------------------------------------------------- channels
  ch_state_e         state_q [NUM_CH];
  ch_state_e         state_d [NUM_CH];
  logic [CNT_BITS-1:0] count_q [NUM_CH];
  logic [CNT_BITS-1:0] count_d [NUM_CH];
  logic [NUM_CH-1:0] clr_req;
  logic [NUM_CH-1:0] pause_req;
  logic [NUM_CH-1:0] tc;
  logic              started_q, started_d;

  assign clr_req   = clr_db | cmd_clr;
  assign pause_req = pause_db | {NUM_CH{~run_q}};
  // Channels sit in RESET for the first edge after reset release.
  assign started_d = 1'b1;

  always_comb begin
    tc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      count_d[i] = count_q[i];
      state_d[i] = state_q[i];
      if (clr_req[i]) begin
        count_d[i] = '0;
        state_d[i] = ST_RESET;
      end else if (load_en[i]) begin
        count_d[i] = lb_wr_d[CNT_BITS-1:0];
        state_d[i] = pause_req[i] ? ST_PAUSE : ST_COUNT;
      end else begin
        case (state_q[i])
          ST_RESET: begin
            if (started_q) begin
              state_d[i] = pause_req[i] ? ST_PAUSE : ST_COUNT;
            end
          end
          ST_DONE: begin
            tc[i] = 1'b1;
          end
          default: begin
            if (pause_req[i]) begin
              state_d[i] = ST_PAUSE;
            end else if (&count_q[i]) begin
              tc[i] = 1'b1;
              if (stop_q[i]) begin
                state_d[i] = ST_DONE;
              end else begin
                count_d[i] = '0;
                state_d[i] = ST_COUNT;
              end
            end else begin
              count_d[i] = count_q[i] + CNT_BITS'(1);
              state_d[i] = ST_COUNT;
            end
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [7:0]          led_q, led_d;
  logic [4*NUM_CH-1:0] sump_q, sump_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_rdy_q, rd_rdy_d;

  always_comb begin
    led_d  = '0;
    sump_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == CTRL_SEL_BITS'(i)) begin
        led_d = count_q[i][CNT_BITS-1 -: 8];
      end
      sump_d[4*i +: 4] = {tc[i], pause_db[i], state_q[i]};
    end
  end

  // Read data is forced to zero outside the single valid cycle.
  always_comb begin
    rd_rdy_d  = rd_en;
    rd_data_d = '0;
    if (rd_en) begin
      case (lb_addr)
        ADDR_CTRL: begin
          rd_data_d[CTRL_RUN_BIT]                    = run_q;
          rd_data_d[CTRL_SEL_LSB +: CTRL_SEL_BITS]   = sel_q;
          rd_data_d[CTRL_STOP_LSB +: MAX_CH]         = stop_q;
        end
        ADDR_STATUS: begin
          for (int i = 0; i < NUM_CH; i++) begin
            rd_data_d[2*i +: 2]             = state_q[i];
            rd_data_d[STATUS_DONE_LSB + i]  = (state_q[i] == ST_DONE);
          end
        end
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (lb_addr == count_addr(i)) begin
              rd_data_d = 32'(count_q[i]);
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b1;
      sel_q     <= '0;
      stop_q    <= '0;
      started_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RESET;
        count_q[i] <= '0;
      end
      led_q     <= '0;
      sump_q    <= '0;
      rd_data_q <= '0;
      rd_rdy_q  <= 1'b0;
    end else begin
      run_q     <= run_d;
      sel_q     <= sel_d;
      stop_q    <= stop_d;
      started_q <= started_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      led_q     <= led_d;
      sump_q    <= sump_d;
      rd_data_q <= rd_data_d;
      rd_rdy_q  <= rd_rdy_d;
    end
  end

  assign led         = led_q;
  assign sump_events = sump_q;
  assign lb_rd_d     = rd_data_q;
  assign lb_rd_rdy   = rd_rdy_q;

endmodule
